// File: rtl/db_thresh_gen.sv
// db_thresh_gen: deblocking threshold generator.
//
// Converts one edge request (qp_p, qp_q, FilterOffsetA/B, bS) into the
// bit-depth-scaled alpha', beta' and tc0' thresholds for the edge filter.
// Two-stage pipeline with valid/ready flow control; full throughput of one
// request per cycle and no bubbles when the downstream stalls.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   valid_i / ready_o          request handshake
//   qp_p_i, qp_q_i [5:0]       QPs of blocks p and q (0..51)
//   off_a_i, off_b_i [OFF_W]   signed FilterOffsetA / FilterOffsetB
//   bs_i [2:0]                 boundary strength 0..4
//   valid_o / ready_i          result handshake
//   alpha_o [BIT_DEPTH]        alpha(indexA) << (BIT_DEPTH-8)
//   beta_o  [BIT_DEPTH-3]      beta(indexB)  << (BIT_DEPTH-8)
//   tc0_o   [BIT_DEPTH-3]      tc0(indexA,bS) << (BIT_DEPTH-8), 0 for bS 0/4
//   filt_en_o                  bS!=0 and alpha'!=0 and beta'!=0
//   strong_o                   bS==4
module db_thresh_gen #(
    parameter int BIT_DEPTH = 8,
    parameter int OFF_W     = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [5:0]           qp_p_i,
    input  logic [5:0]           qp_q_i,
    input  logic [OFF_W-1:0]     off_a_i,
    input  logic [OFF_W-1:0]     off_b_i,
    input  logic [2:0]           bs_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [BIT_DEPTH-1:0] alpha_o,
    output logic [BIT_DEPTH-4:0] beta_o,
    output logic [BIT_DEPTH-4:0] tc0_o,
    output logic                 filt_en_o,
    output logic                 strong_o
);

    localparam int SH = BIT_DEPTH - 8;

    // Clip3(0, 51, v); the signed intermediate lets negative sums land on 0.
    function automatic logic [5:0] clip_idx(input logic signed [7:0] v);
        if (v < 8'sd0)
            return 6'd0;
        else if (v > 8'sd51)
            return 6'd51;
        else
            return 6'(v);
    endfunction

    function automatic logic [7:0] alpha_lut(input logic [5:0] idx);
        case (idx)
            6'd16: return 8'd4;   6'd17: return 8'd4;   6'd18: return 8'd5;   6'd19: return 8'd6;
            6'd20: return 8'd7;   6'd21: return 8'd8;   6'd22: return 8'd9;   6'd23: return 8'd10;
            6'd24: return 8'd12;  6'd25: return 8'd13;  6'd26: return 8'd15;  6'd27: return 8'd17;
            6'd28: return 8'd20;  6'd29: return 8'd22;  6'd30: return 8'd25;  6'd31: return 8'd28;
            6'd32: return 8'd32;  6'd33: return 8'd36;  6'd34: return 8'd40;  6'd35: return 8'd45;
            6'd36: return 8'd50;  6'd37: return 8'd56;  6'd38: return 8'd63;  6'd39: return 8'd71;
            6'd40: return 8'd80;  6'd41: return 8'd90;  6'd42: return 8'd101; 6'd43: return 8'd113;
            6'd44: return 8'd127; 6'd45: return 8'd144; 6'd46: return 8'd162; 6'd47: return 8'd182;
            6'd48: return 8'd203; 6'd49: return 8'd226; 6'd50: return 8'd255; 6'd51: return 8'd255;
            default: return 8'd0;
        endcase
    endfunction

    function automatic logic [4:0] beta_lut(input logic [5:0] idx);
        case (idx)
            6'd16, 6'd17, 6'd18:        return 5'd2;
            6'd19, 6'd20, 6'd21, 6'd22: return 5'd3;
            6'd23, 6'd24, 6'd25:        return 5'd4;
            6'd26, 6'd27:               return 5'd6;
            6'd28, 6'd29:               return 5'd7;
            6'd30, 6'd31:               return 5'd8;
            6'd32, 6'd33:               return 5'd9;
            6'd34, 6'd35:               return 5'd10;
            6'd36, 6'd37:               return 5'd11;
            6'd38, 6'd39:               return 5'd12;
            6'd40, 6'd41:               return 5'd13;
            6'd42, 6'd43:               return 5'd14;
            6'd44, 6'd45:               return 5'd15;
            6'd46, 6'd47:               return 5'd16;
            6'd48, 6'd49:               return 5'd17;
            6'd50, 6'd51:               return 5'd18;
            default:                    return 5'd0;
        endcase
    endfunction

    // Packed {tc0(bS=1), tc0(bS=2), tc0(bS=3)}, five bits each.
    function automatic logic [14:0] tc0_lut(input logic [5:0] idx);
        case (idx)
            6'd17, 6'd18, 6'd19, 6'd20: return {5'd0,  5'd0,  5'd1};
            6'd21, 6'd22:               return {5'd0,  5'd1,  5'd1};
            6'd23, 6'd24, 6'd25, 6'd26: return {5'd1,  5'd1,  5'd1};
            6'd27, 6'd28, 6'd29, 6'd30: return {5'd1,  5'd1,  5'd2};
            6'd31, 6'd32:               return {5'd1,  5'd2,  5'd3};
            6'd33:                      return {5'd2,  5'd2,  5'd3};
            6'd34:                      return {5'd2,  5'd2,  5'd4};
            6'd35, 6'd36:               return {5'd2,  5'd3,  5'd4};
            6'd37:                      return {5'd3,  5'd3,  5'd5};
            6'd38, 6'd39:               return {5'd3,  5'd4,  5'd6};
            6'd40:                      return {5'd4,  5'd5,  5'd7};
            6'd41:                      return {5'd4,  5'd5,  5'd8};
            6'd42:                      return {5'd4,  5'd6,  5'd9};
            6'd43:                      return {5'd5,  5'd7,  5'd10};
            6'd44:                      return {5'd6,  5'd8,  5'd11};
            6'd45:                      return {5'd6,  5'd8,  5'd13};
            6'd46:                      return {5'd7,  5'd10, 5'd14};
            6'd47:                      return {5'd8,  5'd11, 5'd16};
            6'd48:                      return {5'd9,  5'd12, 5'd18};
            6'd49:                      return {5'd10, 5'd13, 5'd20};
            6'd50:                      return {5'd11, 5'd15, 5'd23};
            6'd51:                      return {5'd13, 5'd17, 5'd25};
            default:                    return 15'd0;
        endcase
    endfunction

    logic                 vld_p1, vld_p2;
    logic [5:0]           idx_a_p1, idx_b_p1;
    logic [2:0]           bs_p1;
    logic [BIT_DEPTH-1:0] alpha_p2;
    logic [BIT_DEPTH-4:0] beta_p2, tc0_p2;
    logic                 filt_en_p2, strong_p2;

    logic en1, en2;

    // A stage advances when it is empty or the stage after it is advancing.
    assign en2     = !vld_p2 || ready_i;
    assign en1     = !vld_p1 || en2;
    assign ready_o = en1;

    // ---- stage 1 inputs: average QP and clipped table indices ----
    logic [6:0]        qp_sum;
    logic [5:0]        qp_av;
    logic signed [7:0] off_a_x, off_b_x, sum_a, sum_b;

    assign qp_sum  = 7'(qp_p_i) + 7'(qp_q_i) + 7'd1;
    assign qp_av   = 6'(qp_sum >> 1);
    assign off_a_x = 8'($signed(off_a_i));
    assign off_b_x = 8'($signed(off_b_i));
    assign sum_a   = $signed({2'b00, qp_av}) + off_a_x;
    assign sum_b   = $signed({2'b00, qp_av}) + off_b_x;

    // ---- stage 2 inputs: table lookups from stage-1 registers ----
    logic [7:0]  alpha_raw;
    logic [4:0]  beta_raw, tc0_raw;
    logic [14:0] tc0_all;

    always_comb begin
        alpha_raw = alpha_lut(idx_a_p1);
        beta_raw  = beta_lut(idx_b_p1);
        tc0_all   = tc0_lut(idx_a_p1);
        case (bs_p1)
            3'd1:    tc0_raw = tc0_all[14:10];
            3'd2:    tc0_raw = tc0_all[9:5];
            3'd3:    tc0_raw = tc0_all[4:0];
            default: tc0_raw = 5'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1     <= 1'b0;
            idx_a_p1   <= '0;
            idx_b_p1   <= '0;
            bs_p1      <= '0;
            vld_p2     <= 1'b0;
            alpha_p2   <= '0;
            beta_p2    <= '0;
            tc0_p2     <= '0;
            filt_en_p2 <= 1'b0;
            strong_p2  <= 1'b0;
        end else begin
            // ---- stage 1 register ----
            if (en1) begin
                vld_p1 <= valid_i;
                if (valid_i) begin
                    idx_a_p1 <= clip_idx(sum_a);
                    idx_b_p1 <= clip_idx(sum_b);
                    bs_p1    <= bs_i;
                end
            end
            // ---- stage 2 register ----
            if (en2) begin
                vld_p2 <= vld_p1;
                if (vld_p1) begin
                    alpha_p2   <= BIT_DEPTH'(alpha_raw) << SH;
                    beta_p2    <= (BIT_DEPTH-3)'(beta_raw) << SH;
                    tc0_p2     <= (BIT_DEPTH-3)'(tc0_raw) << SH;
                    filt_en_p2 <= (bs_p1 != 3'd0) && (alpha_raw != 8'd0) && (beta_raw != 5'd0);
                    strong_p2  <= (bs_p1 == 3'd4);
                end
            end
        end
    end

    assign valid_o   = vld_p2;
    assign alpha_o   = alpha_p2;
    assign beta_o    = beta_p2;
    assign tc0_o     = tc0_p2;
    assign filt_en_o = filt_en_p2;
    assign strong_o  = strong_p2;

endmodule

// File: tb/tb_db_thresh_gen.sv
// Testbench for db_thresh_gen: one 8-bit and one 10-bit instance share the
// same stimulus; directed requests with hand-computed thresholds.
module tb_db_thresh_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       valid_i, ready_i;
    logic [5:0] qp_p_i, qp_q_i;
    logic [4:0] off_a_i, off_b_i;
    logic [2:0] bs_i;

    logic       r8, v8, f8, s8;
    logic [7:0] a8;
    logic [4:0] b8, t8;
    logic       r10, v10, f10, s10;
    logic [9:0] a10;
    logic [6:0] b10, t10;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    db_thresh_gen #(.BIT_DEPTH(8), .OFF_W(5)) dut8 (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(r8),
        .qp_p_i(qp_p_i), .qp_q_i(qp_q_i), .off_a_i(off_a_i), .off_b_i(off_b_i),
        .bs_i(bs_i), .valid_o(v8), .ready_i(ready_i), .alpha_o(a8), .beta_o(b8),
        .tc0_o(t8), .filt_en_o(f8), .strong_o(s8)
    );

    db_thresh_gen #(.BIT_DEPTH(10), .OFF_W(5)) dut10 (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(r10),
        .qp_p_i(qp_p_i), .qp_q_i(qp_q_i), .off_a_i(off_a_i), .off_b_i(off_b_i),
        .bs_i(bs_i), .valid_o(v10), .ready_i(ready_i), .alpha_o(a10), .beta_o(b10),
        .tc0_o(t10), .filt_en_o(f10), .strong_o(s10)
    );

    typedef struct {
        int qp_p; int qp_q; int oa; int ob; int bs;
        int al;   int be;   int tc; int fe; int st;
    } vec_t;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        qp_p_i  = 6'(v.qp_p);
        qp_q_i  = 6'(v.qp_q);
        off_a_i = 5'(v.oa);
        off_b_i = 5'(v.ob);
        bs_i    = 3'(v.bs);
    endtask

    // Single request with ready_i held high; result expected two cycles later.
    task automatic run_one(input string tag, input vec_t v, input bit wide);
        @(negedge clk);
        drive(v);
        valid_i = 1'b1;
        ready_i = 1'b1;
        #1 chk({tag, "_rdy"}, 32'(r8), 32'd1);
        @(negedge clk);
        valid_i = 1'b0;
        #1 chk({tag, "_lat1"}, 32'(v8), 32'd0);
        @(negedge clk);
        #1;
        if (wide) begin
            chk({tag, "_vld"},   32'(v10), 32'd1);
            chk({tag, "_alpha"}, 32'(a10), 32'(v.al));
            chk({tag, "_beta"},  32'(b10), 32'(v.be));
            chk({tag, "_tc0"},   32'(t10), 32'(v.tc));
            chk({tag, "_filt"},  32'(f10), 32'(v.fe));
            chk({tag, "_strong"},32'(s10), 32'(v.st));
        end else begin
            chk({tag, "_vld"},   32'(v8), 32'd1);
            chk({tag, "_alpha"}, 32'(a8), 32'(v.al));
            chk({tag, "_beta"},  32'(b8), 32'(v.be));
            chk({tag, "_tc0"},   32'(t8), 32'(v.tc));
            chk({tag, "_filt"},  32'(f8), 32'(v.fe));
            chk({tag, "_strong"},32'(s8), 32'(v.st));
        end
    endtask

    vec_t bp_vec[8];
    vec_t tv;

    initial begin
        int sent, recv, inflight;
        logic acc, cons, stall_prev;
        logic [7:0] sa;
        logic [4:0] sb, st;
        logic sf, ss;

        // Back-pressure vectors, 8-bit thresholds.
        bp_vec[0] = '{30, 30,  0,  0, 2,  25,  8,  1, 1, 0};
        bp_vec[1] = '{40, 40,  0,  0, 1,  80, 13,  4, 1, 0};
        bp_vec[2] = '{51, 51,  0,  0, 3, 255, 18, 25, 1, 0};
        bp_vec[3] = '{20, 21,  0,  0, 0,   8,  3,  0, 0, 0};
        bp_vec[4] = '{26, 27,  2, -3, 2,  22,  4,  1, 1, 0};
        bp_vec[5] = '{36, 35, -4,  4, 3,  32, 13,  3, 1, 0};
        bp_vec[6] = '{45, 46,  5, -2, 1, 255, 15, 13, 1, 0};
        bp_vec[7] = '{16, 17,  0,  0, 4,   4,  2,  0, 1, 1};

        // Reset held 3 cycles with valid_i asserted.
        rst_n   = 1'b0;
        valid_i = 1'b1;
        ready_i = 1'b1;
        drive(bp_vec[0]);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("rst_vld",   32'(v8), 32'd0);
            chk("rst_alpha", 32'(a8), 32'd0);
            chk("rst_beta",  32'(b8), 32'd0);
            chk("rst_tc0",   32'(t8), 32'd0);
            chk("rst_flags", 32'({f8, s8}), 32'd0);
        end
        @(negedge clk);
        rst_n   = 1'b1;
        valid_i = 1'b0;
        @(negedge clk);
        #1 chk("rst_rdy_after", 32'(r8), 32'd1);
        chk("rst_vld_after", 32'(v8), 32'd0);

        tv = '{30, 30, 0, 0, 2, 25, 8, 1, 1, 0};
        run_one("basic", tv, 1'b0);
        // qPav=51 -> indexA=51, indexB=39; beta(39)=12 in the standard table.
        tv = '{50, 51, 12, -12, 3, 255, 12, 25, 1, 0};
        run_one("clip_hi", tv, 1'b0);
        tv = '{10, 10, -12, 0, 4, 0, 0, 0, 0, 1};
        run_one("clip_lo", tv, 1'b0);
        tv = '{40, 40, 0, 0, 1, 320, 52, 16, 1, 0};
        run_one("bd10", tv, 1'b1);
        // Illegal QPs still clip to index 51.
        tv = '{63, 63, 12, 12, 2, 255, 18, 17, 1, 0};
        run_one("qp_ovf", tv, 1'b0);

        // Back-pressure: back-to-back requests with random ready_i.
        sent = 0; recv = 0; inflight = 0; stall_prev = 1'b0;
        sa = '0; sb = '0; st = '0; sf = 1'b0; ss = 1'b0;
        for (int cyc = 0; cyc < 300 && recv < 8; cyc++) begin
            @(negedge clk);
            ready_i = 1'($urandom_range(0, 1));
            if (sent < 8) begin
                drive(bp_vec[sent]);
                valid_i = 1'b1;
            end else begin
                valid_i = 1'b0;
            end
            #1;
            if (stall_prev) begin
                chk("bp_hold_vld",   32'(v8), 32'd1);
                chk("bp_hold_alpha", 32'(a8), 32'(sa));
                chk("bp_hold_beta",  32'(b8), 32'(sb));
                chk("bp_hold_tc0",   32'(t8), 32'(st));
                chk("bp_hold_flags", 32'({f8, s8}), 32'({sf, ss}));
            end
            chk($sformatf("bp_rdy_c%0d", cyc), 32'(r8), 32'(!(inflight == 2 && !ready_i)));
            acc  = valid_i && r8;
            cons = v8 && ready_i;
            if (cons) begin
                chk($sformatf("bp%0d_alpha", recv), 32'(a8), 32'(bp_vec[recv].al));
                chk($sformatf("bp%0d_beta", recv),  32'(b8), 32'(bp_vec[recv].be));
                chk($sformatf("bp%0d_tc0", recv),   32'(t8), 32'(bp_vec[recv].tc));
                chk($sformatf("bp%0d_filt", recv),  32'(f8), 32'(bp_vec[recv].fe));
                chk($sformatf("bp%0d_strong", recv),32'(s8), 32'(bp_vec[recv].st));
                recv++;
            end
            if (acc) sent++;
            inflight = inflight + int'(acc) - int'(cons);
            stall_prev = v8 && !ready_i;
            sa = a8; sb = b8; st = t8; sf = f8; ss = s8;
        end
        valid_i = 1'b0;
        chk("bp_recv_count", 32'(recv), 32'd8);
        chk("bp_inflight", 32'(inflight), 32'd0);

        // Reset mid-flight discards the queued request.
        @(negedge clk);
        ready_i = 1'b1;
        drive(bp_vec[1]);
        valid_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0;
        rst_n   = 1'b0;
        #1 chk("midrst_vld", 32'(v8), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1 chk("midrst_no_out", 32'(v8), 32'd0);
        end
        chk("midrst_alpha", 32'(a8), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
